// File: rtl/mem_access_unit.sv
// Memory access unit: turns controller strobes into one request/grant/read-return
// transaction, with alignment, protocol and timeout error pulses.
module mem_access_unit #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        IorD,
    input  logic        IRWrite,
    input  logic [31:0] PC,
    input  logic [31:0] ALUOut,
    input  logic [31:0] B,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic [31:0] IR,
    output logic [31:0] MDR,
    output logic        mem_busy,
    output logic        err_align,
    output logic        err_proto,
    output logic        err_timeout
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_WAIT_RD = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             fetch_q;
    logic             mem_req_q;
    logic             mem_we_q;
    logic [31:0]      mem_addr_q;
    logic [31:0]      mem_wdata_q;
    logic [31:0]      ir_q;
    logic [31:0]      mdr_q;
    logic             err_align_q;
    logic             err_proto_q;
    logic             err_timeout_q;

    logic [31:0]      sel_addr_c;
    logic             proto_c;
    logic             align_c;
    logic             accept_c;
    logic             last_c;

    // Request decode, only acted upon in IDLE
    always_comb begin
        sel_addr_c = IorD ? ALUOut : PC;
        proto_c    = MemRead & MemWrite;
        align_c    = (MemRead | MemWrite) & (sel_addr_c[1:0] != 2'b00);
        accept_c   = (MemRead ^ MemWrite) & (sel_addr_c[1:0] == 2'b00);
        last_c     = (cnt_q == CNT_W'(TIMEOUT - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            fetch_q       <= 1'b0;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            ir_q          <= '0;
            mdr_q         <= '0;
            err_align_q   <= 1'b0;
            err_proto_q   <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            err_align_q   <= 1'b0;
            err_proto_q   <= 1'b0;
            err_timeout_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (proto_c) begin
                        err_proto_q <= 1'b1;
                    end else if (align_c) begin
                        err_align_q <= 1'b1;
                    end else if (accept_c) begin
                        mem_addr_q  <= sel_addr_c;
                        mem_wdata_q <= B;
                        mem_we_q    <= MemWrite;
                        fetch_q     <= MemRead & IRWrite;
                        mem_req_q   <= 1'b1;
                        cnt_q       <= '0;
                        state_q     <= S_REQ;
                    end
                end
                S_REQ: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    // A granted write completes here and beats a simultaneous timeout
                    if (mem_gnt && mem_we_q) begin
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        state_q   <= S_DONE;
                    end else if (last_c) begin
                        mem_req_q     <= 1'b0;
                        mem_we_q      <= 1'b0;
                        err_timeout_q <= 1'b1;
                        state_q       <= S_IDLE;
                    end else if (mem_gnt) begin
                        mem_req_q <= 1'b0;
                        state_q   <= S_WAIT_RD;
                    end
                end
                S_WAIT_RD: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (mem_rvalid) begin
                        mdr_q <= mem_rdata;
                        if (fetch_q) begin
                            ir_q <= mem_rdata;
                        end
                        state_q <= S_DONE;
                    end else if (last_c) begin
                        err_timeout_q <= 1'b1;
                        state_q       <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Busy covers the accepting IDLE cycle so the controller stalls immediately
    assign mem_busy = ~rst & ((state_q == S_REQ) | (state_q == S_WAIT_RD) |
                              ((state_q == S_IDLE) & accept_c));

    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign IR          = ir_q;
    assign MDR         = mdr_q;
    assign err_align   = err_align_q;
    assign err_proto   = err_proto_q;
    assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vector table, reset sequences and random
// transactions checked against a transaction-level outcome model.
module tb_mem_access_unit;

    localparam int T = 16;
    localparam int WINDOW = 26;

    logic        clk, rst;
    logic        MemRead, MemWrite, IorD, IRWrite;
    logic [31:0] PC, ALUOut, B;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;
    logic [31:0] IR, MDR;
    logic        mem_busy, err_align, err_proto, err_timeout;

    int n_tests = 0;
    int n_fail  = 0;

    // err codes: 0 none, 1 align, 2 proto, 3 timeout
    typedef struct {
        logic        rd, wr, iord, irw, hold;
        logic [31:0] pc, alu, b, rdata;
        int          gd, rvd;
        int          exp_err, exp_req, exp_busy;
        logic [31:0] exp_mdr, exp_ir;
    } vec_t;

    mem_access_unit #(.TIMEOUT(T)) dut (
        .clk(clk), .rst(rst),
        .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD), .IRWrite(IRWrite),
        .PC(PC), .ALUOut(ALUOut), .B(B),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .IR(IR), .MDR(MDR), .mem_busy(mem_busy),
        .err_align(err_align), .err_proto(err_proto), .err_timeout(err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rd, wr, iord, irw, hold,
                                input logic [31:0] pc, alu, b,
                                input int gd, rvd, input logic [31:0] rdata,
                                input int err, req, busy, input logic [31:0] mdr, ir);
        vec_t v;
        v.rd = rd; v.wr = wr; v.iord = iord; v.irw = irw; v.hold = hold;
        v.pc = pc; v.alu = alu; v.b = b; v.gd = gd; v.rvd = rvd; v.rdata = rdata;
        v.exp_err = err; v.exp_req = req; v.exp_busy = busy;
        v.exp_mdr = mdr; v.exp_ir = ir;
        return v;
    endfunction

    // Outcome of one access from the timing rules: grant after gd REQ cycles,
    // read data gd+1+rvd cycles after issue, abort after T busy cycles.
    function automatic vec_t model(input vec_t v, input logic [31:0] mdr, ir);
        vec_t r;
        logic [31:0] ea;
        int total;
        r = v;
        ea = v.iord ? v.alu : v.pc;
        r.exp_mdr = mdr; r.exp_ir = ir;
        r.exp_err = 0; r.exp_req = 0; r.exp_busy = 0;
        total = v.gd + v.rvd + 2;
        if (v.rd && v.wr) r.exp_err = 2;
        else if (!v.rd && !v.wr) r.exp_err = 0;
        else if (ea % 4 != 0) r.exp_err = 1;
        else if (v.wr) begin
            if (v.gd < T) begin r.exp_req = v.gd + 1; r.exp_busy = v.gd + 1; end
            else begin r.exp_req = T; r.exp_busy = T; r.exp_err = 3; end
        end else if (v.gd < T - 1 && total <= T) begin
            r.exp_req = v.gd + 1; r.exp_busy = total;
            r.exp_mdr = v.rdata;
            if (v.irw) r.exp_ir = v.rdata;
        end else if (v.gd < T - 1) begin
            r.exp_req = v.gd + 1; r.exp_busy = T; r.exp_err = 3;
        end else begin
            r.exp_req = T; r.exp_busy = T; r.exp_err = 3;
        end
        return r;
    endfunction

    // Issue one access, act as memory for a fixed window, then compare the tallies
    task automatic run_vec(input vec_t v, input int id);
        logic [31:0] ea;
        int nreq, nbusy, na, np, nt;
        bit bus_bad, we_bad;
        string tag;
        ea = v.iord ? v.alu : v.pc;
        nreq = 0; nbusy = 0; na = 0; np = 0; nt = 0; bus_bad = 0; we_bad = 0;
        tag = $sformatf("v%0d", id);
        @(negedge clk);
        MemRead = v.rd; MemWrite = v.wr; IorD = v.iord; IRWrite = v.irw;
        PC = v.pc; ALUOut = v.alu; B = v.b; mem_rdata = v.rdata;
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        #1 chk({tag, " busy_issue"}, 32'(mem_busy), 32'(v.exp_req > 0));
        for (int k = 0; k < WINDOW; k++) begin
            @(negedge clk);
            if (!v.hold || k > v.exp_busy) begin
                MemRead = 1'b0; MemWrite = 1'b0;
            end
            mem_gnt    = (v.exp_req > 0) && (k == v.gd);
            mem_rvalid = v.rd && !v.wr && (k == v.gd + 1 + v.rvd);
            #1;
            if (mem_req) begin
                nreq++;
                if (mem_addr !== ea || mem_wdata !== v.b || mem_we !== v.wr) bus_bad = 1;
            end else if (mem_we !== 1'b0) begin
                we_bad = 1;
            end
            if (mem_busy)    nbusy++;
            if (err_align)   na++;
            if (err_proto)   np++;
            if (err_timeout) nt++;
        end
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        chk({tag, " req_cycles"},  32'(nreq),  32'(v.exp_req));
        chk({tag, " busy_cycles"}, 32'(nbusy), 32'(v.exp_busy));
        chk({tag, " err_align"},   32'(na),    32'(v.exp_err == 1));
        chk({tag, " err_proto"},   32'(np),    32'(v.exp_err == 2));
        chk({tag, " err_timeout"}, 32'(nt),    32'(v.exp_err == 3));
        chk({tag, " MDR"}, MDR, v.exp_mdr);
        chk({tag, " IR"},  IR,  v.exp_ir);
        chk({tag, " we_low_idle"}, 32'(we_bad), 32'd0);
        if (v.exp_req > 0) chk({tag, " bus_hold"}, 32'(bus_bad), 32'd0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " mem_req"},   32'(mem_req),  32'd0);
        chk({tag, " mem_we"},    32'(mem_we),   32'd0);
        chk({tag, " mem_addr"},  mem_addr,      32'd0);
        chk({tag, " mem_wdata"}, mem_wdata,     32'd0);
        chk({tag, " IR"},        IR,            32'd0);
        chk({tag, " MDR"},       MDR,           32'd0);
        chk({tag, " mem_busy"},  32'(mem_busy), 32'd0);
        chk({tag, " errs"}, 32'({err_align, err_proto, err_timeout}), 32'd0);
    endtask

    vec_t        tbl[13];
    vec_t        v;
    logic [31:0] mdr_m, ir_m, tmp;
    logic [1:0]  lo;
    int          op;

    initial begin
        rst = 1'b1;
        MemRead = 0; MemWrite = 0; IorD = 0; IRWrite = 0;
        PC = 0; ALUOut = 0; B = 0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;

        tbl[0]  = mk(1,0,0,1,0, 32'h40, 0, 0, 0,0, 32'h8C220004, 0,1,2, 32'h8C220004, 32'h8C220004);
        tbl[1]  = mk(0,1,1,0,0, 0, 32'h100, 32'hDEADBEEF, 3,0, 0, 0,4,4, 32'h8C220004, 32'h8C220004);
        tbl[2]  = mk(1,0,1,0,0, 0, 32'h102, 0, 0,0, 32'h55, 1,0,0, 32'h8C220004, 32'h8C220004);
        tbl[3]  = mk(1,1,1,0,0, 0, 32'h100, 0, 0,0, 0, 2,0,0, 32'h8C220004, 32'h8C220004);
        tbl[4]  = mk(1,0,1,0,0, 0, 32'h200, 0, 0,15, 32'h77, 3,1,16, 32'h8C220004, 32'h8C220004);
        tbl[5]  = mk(1,0,1,0,0, 0, 32'h204, 0, 0,14, 32'hCAFEF00D, 0,1,16, 32'hCAFEF00D, 32'h8C220004);
        tbl[6]  = mk(0,1,0,0,0, 32'h300, 0, 32'h11111111, 20,0, 0, 3,16,16, 32'hCAFEF00D, 32'h8C220004);
        tbl[7]  = mk(0,1,1,0,0, 0, 32'h8, 32'h22, 0,0, 0, 0,1,1, 32'hCAFEF00D, 32'h8C220004);
        tbl[8]  = mk(1,0,0,1,0, 32'h44, 0, 0, 2,3, 32'h01234567, 0,3,7, 32'h01234567, 32'h01234567);
        tbl[9]  = mk(0,1,0,0,0, 32'h41, 0, 0, 0,0, 0, 1,0,0, 32'h01234567, 32'h01234567);
        tbl[10] = mk(0,0,0,0,0, 32'h48, 0, 0, 0,0, 32'h99, 0,0,0, 32'h01234567, 32'h01234567);
        tbl[11] = mk(0,1,1,0,1, 0, 32'h10, 32'hABCD, 1,0, 0, 0,2,2, 32'h01234567, 32'h01234567);
        tbl[12] = mk(1,0,0,1,1, 32'h50, 0, 0, 0,0, 32'hFEEDFACE, 0,1,2, 32'hFEEDFACE, 32'hFEEDFACE);

        #1 chk_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) run_vec(tbl[i], i);

        // Asynchronous reset while waiting for read data, then stale read return
        @(negedge clk);
        MemRead = 1'b1; IorD = 1'b0; PC = 32'h60; IRWrite = 1'b1;
        @(negedge clk);
        MemRead = 1'b0; mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        #1 chk("rst_mid busy_before", 32'(mem_busy), 32'd1);
        #1 rst = 1'b1;
        #1 chk_zero("rst_mid");
        @(negedge clk);
        rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
        @(negedge clk);
        mem_rvalid = 1'b0;
        #1 chk("rst_mid MDR_after", MDR, 32'd0);
        chk("rst_mid IR_after", IR, 32'd0);
        chk("rst_mid req_after", 32'(mem_req), 32'd0);
        mdr_m = 32'd0; ir_m = 32'd0;

        for (int n = 0; n < 60; n++) begin
            op = int'($urandom_range(0, 9));
            v.rd = (op == 0) || (op >= 2 && op <= 5);
            v.wr = (op == 0) || (op >= 6);
            v.iord = 1'($urandom_range(0, 1));
            v.irw  = 1'($urandom_range(0, 1));
            lo = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            tmp = $urandom; v.pc  = {tmp[31:2], lo};
            tmp = $urandom; v.alu = {tmp[31:2], lo};
            v.b = $urandom; v.rdata = $urandom;
            v.gd  = v.wr ? int'($urandom_range(0, 20)) : int'($urandom_range(0, 8));
            v.rvd = int'($urandom_range(0, 12));
            v.hold = 1'b0;
            v = model(v, mdr_m, ir_m);
            if (v.exp_err == 0 && v.exp_req > 0 && $urandom_range(0, 3) == 0) v.hold = 1'b1;
            run_vec(v, 100 + n);
            mdr_m = v.exp_mdr; ir_m = v.exp_ir;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter TIMEOUT, default 16: max cycles an access may wait in REQ plus WAIT_RD before abort.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 MemRead, MemWrite  input  1 each  access strobes from controller FSM.
REQ-005 IorD  input  1  address select: 0 = PC, 1 = ALUOut.
REQ-006 IRWrite  input  1  read is an instruction fetch; result also loads IR.
REQ-007 PC, ALUOut, B  input  32 each  fetch address, data address, store data.
REQ-008 mem_req  output  1; mem_we  output  1; mem_addr  output  32; mem_wdata  output  32  memory request bus.
REQ-009 mem_gnt  input  1; mem_rvalid  input  1; mem_rdata  input  32  memory accept and read-return.
REQ-010 IR, MDR  output  32 each  instruction register and memory data register.
REQ-011 mem_busy  output  1  stall to controller; controller holds its state while high.
REQ-012 err_align, err_proto, err_timeout  output  1 each  one-cycle error pulses.

Function
REQ-013 FSM states IDLE, REQ, WAIT_RD, DONE; registered state.
REQ-014 Strobes SHALL be sampled only in IDLE; ignored in REQ, WAIT_RD and DONE.
REQ-015 IDLE, exactly one of MemRead/MemWrite high, aligned address: latch addr = (IorD ? ALUOut : PC), wdata = B, we = MemWrite, fetch = MemRead & IRWrite; go to REQ.
REQ-016 IDLE, MemRead & MemWrite both high: pulse err_proto next cycle, no request, stay IDLE.
REQ-017 IDLE, selected address[1:0] != 0: pulse err_align next cycle, no request, stay IDLE; err_proto takes priority if both conditions hold.
REQ-018 REQ: mem_req=1; mem_addr, mem_wdata, mem_we SHALL hold latched values until the cycle mem_gnt=1.
REQ-019 REQ with mem_gnt: write goes to DONE; read goes to WAIT_RD; mem_req low next cycle.
REQ-020 WAIT_RD with mem_rvalid: MDR <= mem_rdata; if fetch latched, IR <= mem_rdata in the same edge; go to DONE.
REQ-021 mem_rvalid outside WAIT_RD SHALL be ignored; MDR/IR unchanged.
REQ-022 DONE lasts exactly one cycle, mem_busy=0, strobes ignored; then IDLE. This prevents re-issue while controller advances.
REQ-023 mem_busy = (state is REQ or WAIT_RD) OR (state IDLE and a legal access is accepted this cycle); combinational from strobes in IDLE.
REQ-024 Wait counter: cleared on entry to REQ, increments each cycle in REQ/WAIT_RD; at count == TIMEOUT-1 without completion, pulse err_timeout, go to IDLE, MDR/IR unchanged, mem_req low.
REQ-025 Completion and timeout in the same cycle: completion wins, no err_timeout.
REQ-026 Minimum latency: write 2 cycles (IDLE->REQ->DONE with gnt in first REQ cycle); read 3 cycles with gnt then rvalid on consecutive cycles.
REQ-027 mem_we SHALL be 0 whenever mem_req=0.

Reset
REQ-028 rst high SHALL immediately force state IDLE, IR=0, MDR=0, counter=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, all err outputs 0, mem_busy=0.
REQ-029 rst asserted mid-access (REQ or WAIT_RD) SHALL abort it; a later mem_rvalid SHALL NOT update MDR/IR.

Verification
REQ-030 Fetch: IorD=0, PC=0x00000040, MemRead=IRWrite=1; gnt in cycle 1, rvalid in cycle 2 with 0x8C220004 -> mem_addr=0x40, IR=MDR=0x8C220004, DONE one cycle.
REQ-031 Store: IorD=1, ALUOut=0x100, B=0xDEADBEEF, MemWrite=1; gnt delayed 3 cycles -> mem_req/addr/wdata/we stable 4 cycles, mem_busy high throughout, no MDR change.
REQ-032 Misaligned: ALUOut=0x102, IorD=1, MemRead=1 -> err_align one cycle, mem_req never asserted; both strobes high -> err_proto one cycle.
REQ-033 Timeout: read, gnt given, no rvalid for 16 cycles -> err_timeout pulse, IDLE, MDR retains 0; rvalid at cycle 16 -> completion, no error.
REQ-034 Async reset in WAIT_RD, then rvalid with 0x12345678 -> all outputs 0 within same cycle as rst, MDR stays 0.
REQ-035 Strobes held high through DONE -> exactly one memory transaction per strobe assertion.
